// File: rtl/wifi_phy_pkg.sv
// Shared definitions for the Wi-Fi PHY receive path: bank state encoding,
// legal OFDM symbol geometries and the index width used by the
// deinterleaver datapath.
package wifi_phy_pkg;

    // Width of every bit index / counter in the deinterleaver.
    localparam int IDX_W = 11;

    // Legal coded bits per OFDM symbol (BPSK, QPSK, 16-QAM, 64-QAM).
    localparam int N_CBPS_BPSK  = 48;
    localparam int N_CBPS_QPSK  = 96;
    localparam int N_CBPS_16QAM = 192;
    localparam int N_CBPS_64QAM = 288;

    // Legal coded bits per subcarrier.
    localparam int N_BPSC_BPSK  = 1;
    localparam int N_BPSC_QPSK  = 2;
    localparam int N_BPSC_16QAM = 4;
    localparam int N_BPSC_64QAM = 6;

    // Life cycle of one ping-pong storage bank.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // Rotation stride of the second permutation: max(N_BPSC/2, 1).
    function automatic int deint_stride(input int n_bpsc);
        return (n_bpsc / 2 > 1) ? (n_bpsc / 2) : 1;
    endfunction

endpackage

// File: rtl/deint_index.sv
// Combinational inverse-interleaver index map: received position j to
// original coded-bit position k for one OFDM symbol geometry.
module deint_index
    import wifi_phy_pkg::*;
#(
    parameter int N_CBPS = 48,
    parameter int N_BPSC = 1
) (
    input  logic [IDX_W-1:0] j,
    output logic [IDX_W-1:0] k
);

    // 16*j reaches 4592 for the largest symbol, so the intermediate products
    // carry two extra bits; the final k always fits back into IDX_W bits.
    localparam int MATH_W = IDX_W + 2;
    localparam int S      = deint_stride(N_BPSC);

    localparam logic [MATH_W-1:0] NC   = MATH_W'(N_CBPS);
    localparam logic [MATH_W-1:0] NCM1 = MATH_W'(N_CBPS - 1);
    localparam logic [MATH_W-1:0] SW   = MATH_W'(S);

    logic [MATH_W-1:0] j_w;
    logic [MATH_W-1:0] j16;
    logic [MATH_W-1:0] q_j;
    logic [MATH_W-1:0] i_w;
    logic [MATH_W-1:0] i16;
    logic [MATH_W-1:0] q_i;

    // Undo the subcarrier-bit rotation to get i, then undo the column/row
    // spreading to get k.
    always_comb begin
        j_w = MATH_W'(j);
        j16 = j_w << 4;
        q_j = j16 / NC;
        i_w = SW * (j_w / SW) + ((j_w + q_j) % SW);
        i16 = i_w << 4;
        q_i = i16 / NC;
        k   = IDX_W'(i16 - NCM1 * q_i);
    end

endmodule

// File: rtl/deinterleaver.sv
// 802.11a-style block deinterleaver with two ping-pong symbol banks.
// Pairs of received bits are written straight into their original positions;
// a full bank is then read out in natural order, two bits per transfer.
// Optional feature: define DEINTERLEAVER_FLUSH_EN to add the 'flush' input,
// which abandons a partially written symbol.
module deinterleaver
    import wifi_phy_pkg::*;
#(
    parameter int N_CBPS = 48,
    parameter int N_BPSC = 1
) (
`ifdef DEINTERLEAVER_FLUSH_EN
    input  logic       flush,
`endif
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam logic [IDX_W-1:0] WR_LAST = IDX_W'(N_CBPS - 2);
    localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(N_CBPS / 2 - 1);
    localparam logic [N_CBPS-1:0] ONE_HOT0 = N_CBPS'(1);

    bank_state_t       bank_state     [2];
    bank_state_t       bank_state_nxt [2];
    logic              wr_sel, wr_sel_nxt;
    logic              rd_sel, rd_sel_nxt;
    logic [IDX_W-1:0]  wr_cnt, wr_cnt_nxt;
    logic [IDX_W-1:0]  rd_cnt, rd_cnt_nxt;
    logic [N_CBPS-1:0] bank_mem [2];
    logic [IDX_W-1:0]  j_hi;
    logic [IDX_W-1:0]  k_lo;
    logic [IDX_W-1:0]  k_hi;
    logic [N_CBPS-1:0] sel_lo;
    logic [N_CBPS-1:0] sel_hi;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_en;

    assign j_hi = wr_cnt + IDX_W'(1);

    deint_index #(.N_CBPS(N_CBPS), .N_BPSC(N_BPSC)) u_idx_lo (
        .j (wr_cnt),
        .k (k_lo)
    );

    deint_index #(.N_CBPS(N_CBPS), .N_BPSC(N_BPSC)) u_idx_hi (
        .j (j_hi),
        .k (k_hi)
    );

    // Handshake outputs follow the bank states directly; the read pair is
    // forced to zero whenever nothing valid is being offered.
    always_comb begin
        in_ready  = (bank_state[wr_sel] != FULL);
        out_valid = (bank_state[rd_sel] == FULL);
        out_last  = out_valid && (rd_cnt == RD_LAST);
        out_data  = out_valid ? 2'(bank_mem[rd_sel] >> {rd_cnt, 1'b0}) : 2'b00;
    end

    // Next-state of both banks, selectors and counters. Write and read always
    // target different banks, so their completions can land in one cycle.
    always_comb begin
        bank_state_nxt = bank_state;
        wr_sel_nxt     = wr_sel;
        rd_sel_nxt     = rd_sel;
        wr_cnt_nxt     = wr_cnt;
        rd_cnt_nxt     = rd_cnt;
        wr_fire        = in_valid && in_ready;
        rd_fire        = out_valid && out_ready;
        wr_en          = wr_fire;
`ifdef DEINTERLEAVER_FLUSH_EN
        if (flush) begin
            wr_en      = 1'b0;
            wr_cnt_nxt = '0;
            for (int b = 0; b < 2; b++) begin
                if (bank_state[b] == FILLING) begin
                    bank_state_nxt[b] = EMPTY;
                end
            end
        end
`endif
        if (wr_en) begin
            if (wr_cnt == WR_LAST) begin
                bank_state_nxt[wr_sel] = FULL;
                wr_cnt_nxt             = '0;
                wr_sel_nxt             = ~wr_sel;
            end else begin
                bank_state_nxt[wr_sel] = FILLING;
                wr_cnt_nxt             = wr_cnt + IDX_W'(2);
            end
        end
        if (rd_fire) begin
            if (rd_cnt == RD_LAST) begin
                bank_state_nxt[rd_sel] = EMPTY;
                rd_cnt_nxt             = '0;
                rd_sel_nxt             = ~rd_sel;
            end else begin
                rd_cnt_nxt = rd_cnt + IDX_W'(1);
            end
        end
    end

    // Control state register; reset drops every symbol in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            wr_sel        <= 1'b0;
            rd_sel        <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
        end else begin
            bank_state[0] <= bank_state_nxt[0];
            bank_state[1] <= bank_state_nxt[1];
            wr_sel        <= wr_sel_nxt;
            rd_sel        <= rd_sel_nxt;
            wr_cnt        <= wr_cnt_nxt;
            rd_cnt        <= rd_cnt_nxt;
        end
    end

    // One-hot masks for the two target positions of the incoming pair.
    always_comb begin
        sel_lo = ONE_HOT0 << k_lo;
        sel_hi = ONE_HOT0 << k_hi;
    end

    // Bank storage: scatter the accepted pair into its original positions.
    // Contents are never cleared; bank state alone decides what is valid.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            bank_mem[wr_sel] <= (bank_mem[wr_sel] & ~(sel_lo | sel_hi))
                              | (in_data[0] ? sel_lo : '0)
                              | (in_data[1] ? sel_hi : '0);
        end
    end

endmodule
